// File: rtl/einstein_int_ctrl.sv
// ============================================================================
// Module : einstein_int_ctrl
// Z80 IM2 interrupt arbiter for the Einstein KB/ADC/FIRE sources, chained
// with the CTC (KB > CTC > ADC > FIRE). Optional macro: INT_CTRL_ADC_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module einstein_int_ctrl #(
    parameter logic [7:0] VEC_KB   = 8'h0E,
    parameter logic [7:0] VEC_FIRE = 8'h0C,
    parameter logic [7:0] VEC_ADC  = 8'h0A
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       reti,
    input  logic [2:0] req,
    input  logic [2:0] mask_wr,
    input  logic       mask_din,
    input  logic [2:0] clr,
    input  logic       ctc_int_n,
    input  logic       ctc_ieo,
    output logic       ctc_iei,
    output logic       int_n,
    output logic [7:0] vec,
    output logic       vec_oe,
    output logic [2:0] pend
);

`ifdef INT_CTRL_ADC_EN
    localparam logic ADC_EN = 1'b1;
`else
    localparam logic ADC_EN = 1'b0;
`endif

    // Bit order everywhere is {fire, adc, kb}
    localparam logic [2:0] SRC_EN = {1'b1, ADC_EN, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e     state_q;
    logic [2:0] req_d_q;
    logic [2:0] mask_q;
    logic [2:0] pend_q;
    logic [2:0] insrv_q;
    logic       int_n_q;
    logic [7:0] vec_q;
    logic       vec_oe_q;

    logic [2:0] mask_d;
    logic [2:0] pend_d;
    logic [2:0] insrv_d;
    logic [2:0] evt;
    logic [2:0] en;
    logic [2:0] lreq;
    logic [2:0] grant;
    logic [2:0] reti_clr;
    logic       inta;
    logic       en_ctc;
    logic       en_adc;
    logic       en_fire;
    logic       ctc_win;
    logic [7:0] grant_vec;

    always_comb begin
        inta    = ~m1_n & ~iorq_n;
        evt     = req & ~req_d_q & SRC_EN;
        en_ctc  = ~insrv_q[0];
        en_adc  = en_ctc & ctc_ieo;
        en_fire = ADC_EN ? (en_adc & ~insrv_q[1]) : en_adc;
        en      = {en_fire, en_adc, 1'b1};
        lreq    = pend_q & en & ~insrv_q & SRC_EN;
        ctc_win = ~ctc_int_n & en_ctc;

        // Arbitration is only evaluated on the first INTA cycle; the CTC slot
        // sits between KB and ADC and suppresses any lower local winner.
        grant     = 3'b000;
        grant_vec = vec_q;
        if (state_q == ST_IDLE && inta) begin
            if (lreq[0]) begin
                grant     = 3'b001;
                grant_vec = VEC_KB;
            end else if (ctc_win) begin
                grant = 3'b000;
            end else if (lreq[1]) begin
                grant     = 3'b010;
                grant_vec = VEC_ADC;
            end else if (lreq[2]) begin
                grant     = 3'b100;
                grant_vec = VEC_FIRE;
            end
        end

        reti_clr = 3'b000;
        if (reti) begin
            if (insrv_q[0]) begin
                reti_clr = 3'b001;
            end else if (insrv_q[1] && en_adc) begin
                reti_clr = 3'b010;
            end else if (insrv_q[2] && en_fire) begin
                reti_clr = 3'b100;
            end
        end

        for (int i = 0; i < 3; i++) begin
            mask_d[i] = (mask_wr[i] && SRC_EN[i]) ? mask_din : mask_q[i];
        end

        // A fresh event always wins over a clear or a grant in the same cycle
        pend_d  = ((pend_q & ~clr & ~grant) | (evt & ~mask_q)) & SRC_EN;
        insrv_d = ((insrv_q & ~reti_clr) | grant) & SRC_EN;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            req_d_q  <= 3'b000;
            mask_q   <= 3'b111;
            pend_q   <= 3'b000;
            insrv_q  <= 3'b000;
            int_n_q  <= 1'b1;
            vec_q    <= 8'h00;
            vec_oe_q <= 1'b0;
        end else begin
            req_d_q <= req;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            insrv_q <= insrv_d;
            int_n_q <= ctc_int_n & ~(|lreq);
            case (state_q)
                ST_IDLE: begin
                    if (inta) begin
                        state_q <= ST_ACK;
                        if (|grant) begin
                            vec_q    <= grant_vec;
                            vec_oe_q <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    if (!inta) begin
                        state_q  <= ST_WAIT;
                        vec_oe_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    vec_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign ctc_iei = ~insrv_q[0];
    assign int_n   = int_n_q;
    assign vec     = vec_q;
    assign vec_oe  = vec_oe_q;
    assign pend    = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_einstein_int_ctrl.sv
// ============================================================================
// Module : tb_einstein_int_ctrl
// Self-checking bench for einstein_int_ctrl; expected INTA vectors are queued.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_einstein_int_ctrl;

`ifdef INT_CTRL_ADC_EN
    localparam bit ADC = 1'b1;
`else
    localparam bit ADC = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       m1_n;
    logic       iorq_n;
    logic       reti;
    logic [2:0] req;
    logic [2:0] mask_wr;
    logic       mask_din;
    logic [2:0] clr;
    logic       ctc_int_n;
    logic       ctc_ieo;
    logic       ctc_iei;
    logic       int_n;
    logic [7:0] vec;
    logic       vec_oe;
    logic [2:0] pend;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk_sys = ~clk_sys;

    einstein_int_ctrl dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .m1_n      (m1_n),
        .iorq_n    (iorq_n),
        .reti      (reti),
        .req       (req),
        .mask_wr   (mask_wr),
        .mask_din  (mask_din),
        .clr       (clr),
        .ctc_int_n (ctc_int_n),
        .ctc_ieo   (ctc_ieo),
        .ctc_iei   (ctc_iei),
        .int_n     (int_n),
        .vec       (vec),
        .vec_oe    (vec_oe),
        .pend      (pend)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_mask(input logic [2:0] w, input logic d);
        mask_wr  = w;
        mask_din = d;
        step(1);
        mask_wr  = 3'b000;
    endtask

    task automatic pulse(input logic [2:0] r);
        req = r;
        step(1);
        req = 3'b000;
        step(1);
    endtask

    task automatic do_reti();
        reti = 1'b1;
        step(1);
        reti = 1'b0;
    endtask

    // Full INTA cycle: two cycles asserted, then release and return to IDLE
    task automatic do_inta(input logic exp_oe, input logic [7:0] exp_vec);
        logic [8:0] e;
        exp_q.push_back({exp_oe, exp_vec});
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        step(1);
        e = exp_q.pop_front();
        chk("inta_oe", {31'd0, vec_oe}, {31'd0, e[8]});
        if (e[8]) chk("inta_vec", {24'd0, vec}, {24'd0, e[7:0]});
        step(1);
        chk("ack_hold_oe", {31'd0, vec_oe}, {31'd0, e[8]});
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        step(1);
        chk("ack_end_oe", {31'd0, vec_oe}, 32'd0);
        if (e[8]) chk("vec_hold", {24'd0, vec}, {24'd0, e[7:0]});
        step(1);
    endtask

    initial begin
        logic [8:0] e;
        reset = 1'b1; m1_n = 1'b1; iorq_n = 1'b1; reti = 1'b0;
        req = 3'b000; mask_wr = 3'b000; mask_din = 1'b0; clr = 3'b000;
        ctc_int_n = 1'b1; ctc_ieo = 1'b1;
        step(2);
        reset = 1'b0;
        chk("rst_pend", {29'd0, pend}, 32'd0);
        chk("rst_oe", {31'd0, vec_oe}, 32'd0);
        chk("rst_vec", {24'd0, vec}, 32'd0);
        chk("rst_int_n", {31'd0, int_n}, 32'd1);
        chk("rst_iei", {31'd0, ctc_iei}, 32'd1);

        // 1: keyboard request, one clock of int_n latency, vector 0E
        do_mask(3'b001, 1'b0);
        req = 3'b001;
        step(1);
        chk("t1_pend", {29'd0, pend}, 32'd1);
        chk("t1_int_n_lat", {31'd0, int_n}, 32'd1);
        req = 3'b000;
        step(1);
        chk("t1_int_n", {31'd0, int_n}, 32'd0);
        do_inta(1'b1, 8'h0E);
        chk("t1_pend_clr", {29'd0, pend}, 32'd0);
        chk("t1_iei", {31'd0, ctc_iei}, 32'd0);

        // 2: fire blocked while KB in service, released by RETI
        do_mask(3'b100, 1'b0);
        pulse(3'b100);
        step(1);
        chk("t2_pend", {29'd0, pend}, 32'd4);
        chk("t2_int_n_blk", {31'd0, int_n}, 32'd1);
        do_reti();
        step(2);
        chk("t2_int_n", {31'd0, int_n}, 32'd0);
        do_inta(1'b1, 8'h0C);
        do_reti();

        // 3: simultaneous events resolved one INTA at a time
        do_mask(3'b010, 1'b0);
        pulse(3'b111);
        chk("t3_pend", {29'd0, pend}, ADC ? 32'd7 : 32'd5);
        do_inta(1'b1, 8'h0E);
        do_reti();
        do_inta(1'b1, ADC ? 8'h0A : 8'h0C);
        do_reti();
        do_inta(ADC, 8'h0C);
        do_reti();
        chk("t3_pend_end", {29'd0, pend}, 32'd0);

        // 4: CTC owns the bus, then RETI with ctc_ieo low is ignored
        pulse(3'b110);
        ctc_int_n = 1'b0;
        step(2);
        chk("t4_int_n_ctc", {31'd0, int_n}, 32'd0);
        do_inta(1'b0, 8'h00);
        chk("t4_pend_kept", {29'd0, pend}, ADC ? 32'd6 : 32'd4);
        ctc_int_n = 1'b1;
        do_inta(1'b1, ADC ? 8'h0A : 8'h0C);
        pulse(3'b100);
        step(1);
        chk("t4_fire_pend", {31'd0, pend[2]}, 32'd1);
        chk("t4_int_n_blk", {31'd0, int_n}, 32'd1);
        ctc_ieo = 1'b0;
        do_reti();
        ctc_ieo = 1'b1;
        step(2);
        chk("t4_reti_noop", {31'd0, int_n}, 32'd1);
        do_reti();
        step(2);
        chk("t4_reti_ok", {31'd0, int_n}, 32'd0);
        do_inta(1'b1, 8'h0C);
        do_reti();

        // 5: masking and clear-versus-set priority
        do_mask(3'b001, 1'b1);
        pulse(3'b001);
        chk("t5_masked", {29'd0, pend}, 32'd0);
        do_mask(3'b001, 1'b0);
        clr = 3'b001;
        req = 3'b001;
        step(1);
        clr = 3'b000;
        req = 3'b000;
        chk("t5_set_wins", {31'd0, pend[0]}, 32'd1);
        do_mask(3'b001, 1'b1);
        chk("t5_mask_keeps", {31'd0, pend[0]}, 32'd1);
        clr = 3'b001;
        step(1);
        clr = 3'b000;
        chk("t5_clr", {29'd0, pend}, 32'd0);
        do_mask(3'b001, 1'b0);

        // 6: reset in the middle of an acknowledge
        pulse(3'b001);
        exp_q.push_back({1'b1, 8'h0E});
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        step(1);
        e = exp_q.pop_front();
        chk("t6_oe", {31'd0, vec_oe}, {31'd0, e[8]});
        chk("t6_vec", {24'd0, vec}, {24'd0, e[7:0]});
        chk("t6_iei", {31'd0, ctc_iei}, 32'd0);
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        chk("t6_rst_oe", {31'd0, vec_oe}, 32'd0);
        chk("t6_rst_pend", {29'd0, pend}, 32'd0);
        chk("t6_rst_iei", {31'd0, ctc_iei}, 32'd1);
        chk("t6_rst_int_n", {31'd0, int_n}, 32'd1);
        pulse(3'b001);
        chk("t6_rst_mask", {29'd0, pend}, 32'd0);
        do_mask(3'b010, 1'b0);
        pulse(3'b010);
        chk("t6_adc_cfg", {29'd0, pend}, ADC ? 32'd2 : 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
